// File: rtl/jtvigil_pcm_pkg.sv
// Shared types and widths for the PCM sample fetcher.
package jtvigil_pcm_pkg;

  localparam int unsigned PCM_DW = 8;
  localparam int unsigned PCM_AW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_D = 2'd1,
    WAIT_P = 2'd2
  } pcm_state_t;

endpackage

// File: rtl/jtvigil_pcm_entry.sv
// One tagged sample byte: tag/data/valid register with write, clear and address match.
module jtvigil_pcm_entry
  import jtvigil_pcm_pkg::*;
#(
  parameter int unsigned AW = PCM_AW,
  parameter int unsigned DW = PCM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic          i_clr,
  input  logic [AW-1:0] i_wtag,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_addr,
  output logic          o_match,
  output logic [DW-1:0] o_data,
  output logic [AW-1:0] o_tag,
  output logic          o_valid
);

  logic [AW-1:0] r_tag;
  logic [DW-1:0] r_data;
  logic          r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_we) begin
      r_tag   <= i_wtag;
      r_data  <= i_wdata;
      r_valid <= 1'b1;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end
  end

  assign o_match = r_valid && (r_tag == i_addr);
  assign o_data  = r_data;
  assign o_tag   = r_tag;
  assign o_valid = r_valid;

endmodule

// File: rtl/jtvigil_pcm_fetch.sv
// PCM sample fetcher: demand entry D plus optional sequential prefetch entry P
// (enabled by JTVIGIL_PCM_PREFETCH_EN) in front of one SDRAM read slot.
module jtvigil_pcm_fetch
  import jtvigil_pcm_pkg::*;
#(
  parameter int unsigned AW = PCM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcm_cs,
  input  logic [AW-1:0]     pcm_addr,
  output logic [PCM_DW-1:0] pcm_data,
  output logic              pcm_ok,
  output logic              mem_req,
  output logic [AW-1:0]     mem_addr,
  input  logic              mem_rdy,
  input  logic [PCM_DW-1:0] mem_data
);

  pcm_state_t        r_state, w_state_nxt;
  logic              r_mem_req;
  logic [AW-1:0]     r_mem_addr;

  logic              w_d_hit, w_d_valid, w_d_we;
  logic [PCM_DW-1:0] w_d_data, w_d_wdata;
  logic [AW-1:0]     w_d_tag, w_d_wtag;

  logic              w_p_hit, w_p_we, w_p_clr, w_p_nxt_hit;
  logic [PCM_DW-1:0] w_p_data;
  logic [AW-1:0]     w_p_tag;

  logic              w_req_set;
  logic [AW-1:0]     w_req_addr;
  logic              w_unused_d;

  jtvigil_pcm_entry #(
    .AW (AW),
    .DW (PCM_DW)
  ) u_entry_d (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_d_we),
    .i_clr   (1'b0),
    .i_wtag  (w_d_wtag),
    .i_wdata (w_d_wdata),
    .i_addr  (pcm_addr),
    .o_match (w_d_hit),
    .o_data  (w_d_data),
    .o_tag   (w_d_tag),
    .o_valid (w_d_valid)
  );

  assign w_unused_d = ^{w_d_tag, w_d_valid};

`ifdef JTVIGIL_PCM_PREFETCH_EN
  logic          w_p_valid;
  logic [AW-1:0] w_addr_inc;

  assign w_addr_inc  = pcm_addr + {{(AW-1){1'b0}}, 1'b1};
  assign w_p_nxt_hit = w_p_valid && (w_p_tag == w_addr_inc);

  jtvigil_pcm_entry #(
    .AW (AW),
    .DW (PCM_DW)
  ) u_entry_p (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_p_we),
    .i_clr   (w_p_clr),
    .i_wtag  (r_mem_addr),
    .i_wdata (mem_data),
    .i_addr  (pcm_addr),
    .o_match (w_p_hit),
    .o_data  (w_p_data),
    .o_tag   (w_p_tag),
    .o_valid (w_p_valid)
  );
`else
  assign w_p_hit     = 1'b0;
  assign w_p_data    = '0;
  assign w_p_tag     = '0;
  assign w_p_nxt_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (pcm_cs && !w_d_hit && !w_p_hit) begin
          w_state_nxt = WAIT_D;
`ifdef JTVIGIL_PCM_PREFETCH_EN
        end else if (pcm_cs && w_d_hit && !w_p_nxt_hit) begin
          w_state_nxt = WAIT_P;
`endif
        end
      end
      WAIT_D:  if (mem_rdy) w_state_nxt = IDLE;
      WAIT_P:  if (mem_rdy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Entry writes, the P-to-D promotion and the next request address
  always_comb begin
    w_d_we     = 1'b0;
    w_d_wtag   = r_mem_addr;
    w_d_wdata  = mem_data;
    w_p_we     = 1'b0;
    w_p_clr    = 1'b0;
    w_req_set  = 1'b0;
    w_req_addr = pcm_addr;
    unique case (r_state)
      IDLE: begin
        if (w_p_hit && !w_d_hit) begin
          w_d_we    = 1'b1;
          w_d_wtag  = w_p_tag;
          w_d_wdata = w_p_data;
          w_p_clr   = 1'b1;
        end
        if (w_state_nxt == WAIT_D) begin
          w_req_set = 1'b1;
        end else if (w_state_nxt == WAIT_P) begin
          w_req_set  = 1'b1;
          w_req_addr = pcm_addr + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      WAIT_D:  w_d_we = mem_rdy;
      WAIT_P:  w_p_we = mem_rdy;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else if (w_req_set) begin
      r_mem_req  <= 1'b1;
      r_mem_addr <= w_req_addr;
    end else if (r_state != IDLE && mem_rdy) begin
      r_mem_req  <= 1'b0;
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;

  always_comb begin
    pcm_ok   = w_d_hit || w_p_hit;
    pcm_data = '0;
    if (w_d_hit)      pcm_data = w_d_data;
    else if (w_p_hit) pcm_data = w_p_data;
  end

endmodule

// File: tb/tb_jtvigil_pcm_fetch.sv
// Directed vector bench for jtvigil_pcm_fetch; follows JTVIGIL_PCM_PREFETCH_EN like the RTL.
module tb_jtvigil_pcm_fetch;

  typedef struct {
    logic        rst;
    logic        cs;
    logic [15:0] addr;
    logic        rdy;
    logic [7:0]  mdata;
    logic        e_req;
    logic [15:0] e_maddr;
    logic        e_ok;
    logic [7:0]  e_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcm_cs;
  logic [15:0] pcm_addr;
  logic [7:0]  pcm_data;
  logic        pcm_ok;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_rdy;
  logic [7:0]  mem_data;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_reqs   = 0;
  logic r_req_prev = 1'b0;
  vec_t tv[$];

  jtvigil_pcm_fetch #(
    .AW (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pcm_cs   (pcm_cs),
    .pcm_addr (pcm_addr),
    .pcm_data (pcm_data),
    .pcm_ok   (pcm_ok),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdy  (mem_rdy),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req === 1'b1 && r_req_prev !== 1'b1) n_reqs++;
    r_req_prev <= mem_req;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic cs, input logic [15:0] a, input logic rdy,
                     input logic [7:0] md, input logic ereq, input logic [15:0] ema,
                     input logic eok, input logic [7:0] ed);
    vec_t v;
    v.rst = r; v.cs = cs; v.addr = a; v.rdy = rdy; v.mdata = md;
    v.e_req = ereq; v.e_maddr = ema; v.e_ok = eok; v.e_data = ed;
    tv.push_back(v);
  endtask

  initial begin
    int  k;
    bool_wait: begin end
    rst = 1'b1; pcm_cs = 1'b0; pcm_addr = '0; mem_rdy = 1'b0; mem_data = '0;

`ifdef JTVIGIL_PCM_PREFETCH_EN
    //   rst cs addr     rdy mdata  req maddr    ok data
    add(0, 0, 16'h1234, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    add(0, 1, 16'h1234, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    add(0, 1, 16'h1234, 0, 8'h00, 1, 16'h1234, 0, 8'h00);
    add(0, 1, 16'h1234, 0, 8'h00, 1, 16'h1234, 0, 8'h00);
    add(0, 1, 16'h1234, 1, 8'h5A, 1, 16'h1234, 0, 8'h00);
    add(0, 1, 16'h1234, 0, 8'h00, 0, 16'h1234, 1, 8'h5A);
    add(0, 1, 16'h1234, 0, 8'h00, 1, 16'h1235, 1, 8'h5A);
    add(0, 1, 16'h1234, 1, 8'h77, 1, 16'h1235, 1, 8'h5A);
    add(0, 1, 16'h1235, 0, 8'h00, 0, 16'h1235, 1, 8'h77);
    add(0, 1, 16'h1235, 0, 8'h00, 0, 16'h1235, 1, 8'h77);
    add(0, 1, 16'h1235, 1, 8'h78, 1, 16'h1236, 1, 8'h77);
    add(0, 1, 16'hFFFF, 0, 8'h00, 0, 16'h1236, 0, 8'h00);
    add(0, 1, 16'hFFFF, 1, 8'hF0, 1, 16'hFFFF, 0, 8'h00);
    add(0, 1, 16'hFFFF, 0, 8'h00, 0, 16'hFFFF, 1, 8'hF0);
    add(0, 1, 16'hFFFF, 1, 8'h0F, 1, 16'h0000, 1, 8'hF0);
    add(0, 1, 16'h0000, 0, 8'h00, 0, 16'h0000, 1, 8'h0F);
`else
    //   rst cs addr     rdy mdata  req maddr    ok data
    add(0, 0, 16'h1234, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    add(0, 1, 16'h1234, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    add(0, 1, 16'h1234, 0, 8'h00, 1, 16'h1234, 0, 8'h00);
    add(0, 1, 16'h1234, 0, 8'h00, 1, 16'h1234, 0, 8'h00);
    add(0, 1, 16'h1234, 1, 8'h5A, 1, 16'h1234, 0, 8'h00);
    add(0, 1, 16'h1234, 0, 8'h00, 0, 16'h1234, 1, 8'h5A);
    // request cannot be cancelled by an address change
    add(0, 1, 16'h1000, 0, 8'h00, 0, 16'h1234, 0, 8'h00);
    add(0, 1, 16'h2000, 0, 8'h00, 1, 16'h1000, 0, 8'h00);
    add(0, 1, 16'h2000, 1, 8'h3C, 1, 16'h1000, 0, 8'h00);
    add(0, 1, 16'h1000, 0, 8'h00, 0, 16'h1000, 1, 8'h3C);
    add(0, 1, 16'h2000, 0, 8'h00, 0, 16'h1000, 0, 8'h00);
    add(0, 1, 16'h2000, 0, 8'h00, 1, 16'h2000, 0, 8'h00);
    add(0, 1, 16'h2000, 1, 8'h99, 1, 16'h2000, 0, 8'h00);
    add(0, 1, 16'h2000, 0, 8'h00, 0, 16'h2000, 1, 8'h99);
    // reset in the middle of a fetch, then a stale mem_rdy
    add(0, 1, 16'h3000, 0, 8'h00, 0, 16'h2000, 0, 8'h00);
    add(0, 1, 16'h3000, 0, 8'h00, 1, 16'h3000, 0, 8'h00);
    add(1, 1, 16'h3000, 0, 8'h00, 1, 16'h3000, 0, 8'h00);
    add(0, 0, 16'h3000, 1, 8'hEE, 0, 16'h0000, 0, 8'h00);
    add(0, 0, 16'h3000, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    add(0, 0, 16'h2000, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    // stepping addresses, one round trip each
    add(0, 1, 16'h0010, 0, 8'h00, 0, 16'h0000, 0, 8'h00);
    add(0, 1, 16'h0010, 1, 8'hA0, 1, 16'h0010, 0, 8'h00);
    add(0, 1, 16'h0010, 0, 8'h00, 0, 16'h0010, 1, 8'hA0);
    add(0, 1, 16'h0011, 0, 8'h00, 0, 16'h0010, 0, 8'h00);
    add(0, 1, 16'h0011, 1, 8'hA1, 1, 16'h0011, 0, 8'h00);
    add(0, 1, 16'h0011, 0, 8'h00, 0, 16'h0011, 1, 8'hA1);
    add(0, 1, 16'h0012, 0, 8'h00, 0, 16'h0011, 0, 8'h00);
    add(0, 1, 16'h0012, 1, 8'hA2, 1, 16'h0012, 0, 8'h00);
    add(0, 1, 16'h0012, 0, 8'h00, 0, 16'h0012, 1, 8'hA2);
`endif

    repeat (2) @(posedge clk);
    #1;
    foreach (tv[i]) begin
      rst = tv[i].rst; pcm_cs = tv[i].cs; pcm_addr = tv[i].addr;
      mem_rdy = tv[i].rdy; mem_data = tv[i].mdata;
      #1;
      check($sformatf("v%0d mem_req", i),  {31'd0, mem_req},  {31'd0, tv[i].e_req});
      check($sformatf("v%0d mem_addr", i), {16'd0, mem_addr}, {16'd0, tv[i].e_maddr});
      check($sformatf("v%0d pcm_ok", i),   {31'd0, pcm_ok},   {31'd0, tv[i].e_ok});
      check($sformatf("v%0d pcm_data", i), {24'd0, pcm_data}, {24'd0, tv[i].e_data});
      @(posedge clk);
      #1;
    end
    rst = 1'b0; mem_rdy = 1'b0;

`ifdef JTVIGIL_PCM_PREFETCH_EN
    check("request count", n_reqs, 5);
`else
    check("request count", n_reqs, 7);
`endif

    // Hand sequence: reset, then a bounded wait for the fetch and its completion
    rst = 1'b1; pcm_cs = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post-reset pcm_ok", {31'd0, pcm_ok}, 32'd0);
    pcm_cs = 1'b1; pcm_addr = 16'h4000;
    k = 0;
    while (mem_req !== 1'b1 && k < 10) begin
      @(posedge clk); #1; k++;
    end
    check("req seen in time", {31'd0, mem_req}, 32'd1);
    check("req addr 0x4000", {16'd0, mem_addr}, 32'h4000);
    repeat (2) @(posedge clk);
    #1;
    mem_rdy = 1'b1; mem_data = 8'h42;
    @(posedge clk); #1;
    mem_rdy = 1'b0;
    check("req dropped after rdy", {31'd0, mem_req}, 32'd0);
    check("ok after rdy", {31'd0, pcm_ok}, 32'd1);
    check("data after rdy", {24'd0, pcm_data}, 32'h42);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
